// File: rtl/instr_mem_ctrl.sv
// rtl/instr_mem_ctrl.sv - instruction memory with program loader and pipelined fetch port
module instr_mem_ctrl #(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 11,
    parameter int                DEPTH    = 2048,
    parameter int                READ_LAT = 1,
    parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
    input  logic              clka,
    input  logic              rst,
    input  logic              load_en,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ready,
    output logic [ADDR_W:0]   load_count,
    output logic              load_done,
    input  logic              run_en,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    input  logic              fetch_stall,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] fetch_data,
    output logic [ADDR_W-1:0] fetch_addr_out,
    output logic              fetch_fault,
    output logic              busy
);
    localparam int              MEM_AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;
    state_t state, state_nx;

    always_ff @(posedge clka) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (load_en) state_nx = LOAD;
                  else if (run_en) state_nx = RUN;
            LOAD: if (!load_en) state_nx = IDLE;
            RUN:  if (load_en) state_nx = LOAD;
                  else if (!run_en) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    logic in_load, in_run, leave_run, advance, accept, addr_ok, wr_en;
    assign in_load    = (state == LOAD);
    assign in_run     = (state == RUN);
    assign busy       = (state != IDLE);
    assign leave_run  = in_run && (state_nx != RUN);
    assign advance    = in_run && !leave_run && !fetch_stall;
    assign accept     = advance && fetch_req;
    assign addr_ok    = ({1'b0, fetch_addr} < DEPTH_C);
    assign load_ready = in_load && (load_count < DEPTH_C);
    assign wr_en      = load_ready && load_valid;

    // load_count doubles as the write pointer and saturates at DEPTH
    always_ff @(posedge clka) begin
        if (rst) begin
            load_count <= '0;
            load_done  <= 1'b0;
        end else if (!in_load && state_nx == LOAD) begin
            load_count <= '0;
            load_done  <= 1'b0;
        end else if (in_load) begin
            if (wr_en) load_count <= load_count + (ADDR_W+1)'(1);
            if (state_nx == IDLE) load_done <= 1'b1;
        end
    end

    // Single-port RAM: loading and fetching are mutually exclusive states
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata;
    logic [MEM_AW-1:0] ram_addr;

    always_comb begin
        ram_addr = fetch_addr[MEM_AW-1:0];
        if (in_load) ram_addr = load_count[MEM_AW-1:0];
    end

    always_ff @(posedge clka) begin
        if (wr_en)                  mem[ram_addr] <= load_data;
        else if (accept && addr_ok) rdata <= mem[ram_addr];
    end

    logic              v1, f1;
    logic [ADDR_W-1:0] a1;

    always_ff @(posedge clka) begin
        if (rst) begin
            v1 <= 1'b0;
            a1 <= '0;
            f1 <= 1'b0;
        end else if (leave_run) begin
            v1 <= 1'b0;
        end else if (advance) begin
            v1 <= fetch_req;
            a1 <= fetch_addr;
            f1 <= !addr_ok;
        end
    end

    generate
        if (READ_LAT == 2) begin : g_lat2
            logic              v2, f2;
            logic [ADDR_W-1:0] a2;
            logic [DATA_W-1:0] d2;

            always_ff @(posedge clka) begin
                if (rst) begin
                    v2 <= 1'b0;
                    a2 <= '0;
                    f2 <= 1'b0;
                    d2 <= '0;
                end else if (leave_run) begin
                    v2 <= 1'b0;
                end else if (advance) begin
                    v2 <= v1;
                    a2 <= a1;
                    f2 <= v1 & f1;
                    d2 <= v1 ? (f1 ? NOP_WORD : rdata) : '0;
                end
            end

            assign fetch_valid    = v2;
            assign fetch_addr_out = a2;
            assign fetch_fault    = f2;
            assign fetch_data     = d2;
        end else begin : g_lat1
            assign fetch_valid    = v1;
            assign fetch_addr_out = a1;
            assign fetch_fault    = v1 & f1;
            assign fetch_data     = v1 ? (f1 ? NOP_WORD : rdata) : '0;
        end
    endgenerate
endmodule

// File: tb/tb_instr_mem_ctrl.sv
// tb/tb_instr_mem_ctrl.sv - randomized and directed bench for instr_mem_ctrl
module tb_instr_mem_ctrl;
    localparam int          DW    = 32;
    localparam int          AW    = 5;
    localparam int          DEPTH = 16;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1, load_en = 1'b0, load_valid = 1'b0, run_en = 1'b0;
    logic          fetch_req = 1'b0, fetch_stall = 1'b0;
    logic [DW-1:0] load_data = '0;
    logic [AW-1:0] fetch_addr = '0;

    logic          rdy1, done1, fv1, ff1, busy1, rdy2, done2, fv2, ff2, busy2;
    logic [AW:0]   lc1, lc2;
    logic [DW-1:0] fd1, fd2;
    logic [AW-1:0] fa1, fa2;

    instr_mem_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .READ_LAT(1), .NOP_WORD(NOP)) u_lat1 (
        .clka(clk), .rst(rst), .load_en(load_en), .load_valid(load_valid), .load_data(load_data),
        .load_ready(rdy1), .load_count(lc1), .load_done(done1), .run_en(run_en),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_stall(fetch_stall),
        .fetch_valid(fv1), .fetch_data(fd1), .fetch_addr_out(fa1), .fetch_fault(ff1), .busy(busy1));

    instr_mem_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .READ_LAT(2), .NOP_WORD(NOP)) u_lat2 (
        .clka(clk), .rst(rst), .load_en(load_en), .load_valid(load_valid), .load_data(load_data),
        .load_ready(rdy2), .load_count(lc2), .load_done(done2), .run_en(run_en),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_stall(fetch_stall),
        .fetch_valid(fv2), .fetch_data(fd2), .fetch_addr_out(fa2), .fetch_fault(ff2), .busy(busy2));

    int n_run = 0, n_fail = 0;
    bit chk_on = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: mode (0 idle, 1 load, 2 run), word count, and a log of pipeline advances
    typedef struct {
        bit          v;
        int          addr;
        bit          known;
        logic [31:0] data;
    } rec_t;

    int          st = 0, cnt = 0;
    bit          done_m = 0;
    logic [31:0] mem_m [DEPTH];
    bit          known_m [DEPTH];
    rec_t        log_q[$];

    always @(posedge clk) begin
        rec_t r;
        if (rst) begin
            st = 0; cnt = 0; done_m = 0; log_q.delete();
        end else begin
            case (st)
                0: if (load_en) begin st = 1; cnt = 0; done_m = 0; end
                   else if (run_en) st = 2;
                1: begin
                    if (load_valid && cnt < DEPTH) begin
                        mem_m[cnt] = load_data; known_m[cnt] = 1; cnt++;
                    end
                    if (!load_en) begin st = 0; done_m = 1; end
                end
                default: begin
                    if (load_en || !run_en) begin
                        log_q.delete();
                        if (load_en) begin st = 1; cnt = 0; done_m = 0; end
                        else st = 0;
                    end else if (!fetch_stall) begin
                        r.v = fetch_req;
                        r.addr = int'(fetch_addr);
                        r.known = (r.addr < DEPTH) && known_m[r.addr % DEPTH];
                        r.data = mem_m[r.addr % DEPTH];
                        log_q.push_back(r);
                        if (log_q.size() > 4) void'(log_q.pop_front());
                    end
                end
            endcase
        end
    end

    function automatic rec_t exp_rec(input int lat);
        rec_t e;
        e.v = 0; e.addr = 0; e.known = 0; e.data = '0;
        if (log_q.size() >= lat) e = log_q[log_q.size() - lat];
        return e;
    endfunction

    task automatic cmp(input int lat, input logic bz, input logic rdy, input logic [AW:0] lc,
                       input logic dn, input logic fv, input logic [AW-1:0] fa,
                       input logic ff, input logic [DW-1:0] fd);
        rec_t r;
        r = exp_rec(lat);
        chk($sformatf("L%0d busy", lat), bz, st != 0);
        chk($sformatf("L%0d load_ready", lat), rdy, (st == 1) && (cnt < DEPTH));
        chk($sformatf("L%0d load_count", lat), lc, cnt);
        chk($sformatf("L%0d load_done", lat), dn, done_m);
        chk($sformatf("L%0d fetch_valid", lat), fv, r.v);
        if (r.v) begin
            chk($sformatf("L%0d fetch_addr_out", lat), fa, r.addr);
            chk($sformatf("L%0d fetch_fault", lat), ff, r.addr >= DEPTH);
            if (r.addr >= DEPTH) chk($sformatf("L%0d fetch_data nop", lat), fd, NOP);
            else if (r.known)    chk($sformatf("L%0d fetch_data", lat), fd, r.data);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            cmp(1, busy1, rdy1, lc1, done1, fv1, fa1, ff1, fd1);
            cmp(2, busy2, rdy2, lc2, done2, fv2, fa2, ff2, fd2);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] w [4];

    initial begin
        int mode;
        w[0] = 32'h1111_1111; w[1] = 32'h2222_2222; w[2] = 32'h3333_3333; w[3] = 32'h4444_4444;

        cyc(); chk_on = 1; cyc();
        chk("reset fetch_data L1", fd1, 32'h0);
        chk("reset fetch_data L2", fd2, 32'h0);
        chk("reset load_count", lc1, 0);

        rst = 0; load_en = 1; cyc();
        chk("load entry ready", rdy1, 1);
        for (int i = 0; i < 4; i++) begin
            load_valid = 1; load_data = w[i]; cyc();
        end
        load_valid = 0; load_en = 0; cyc();
        chk("load 4 count", lc1, 4);
        chk("load 4 done", done1, 1);

        run_en = 1; cyc();
        for (int i = 0; i < 4; i++) begin
            fetch_req = 1; fetch_addr = AW'(i); cyc();
            chk($sformatf("b2b L1 data %0d", i), fd1, w[i]);
            chk($sformatf("b2b L1 addr %0d", i), fa1, i);
            if (i > 0) chk($sformatf("b2b L2 data %0d", i), fd2, w[i-1]);
        end

        fetch_addr = 2; cyc();
        fetch_stall = 1; fetch_addr = 3;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("stall L1 data hold", fd1, 32'h3333_3333);
            chk("stall L1 valid hold", fv1, 1);
        end
        fetch_stall = 0; cyc();
        chk("stall release L2 data", fd2, 32'h3333_3333);
        chk("stall release L1 data", fd1, 32'h4444_4444);

        fetch_addr = 20; cyc();
        chk("fault L1 flag", ff1, 1);
        chk("fault L1 nop", fd1, NOP);
        fetch_addr = 1; cyc();
        chk("fault clear L1", ff1, 0);
        chk("fault L2 nop", fd2, NOP);
        fetch_req = 0; cyc(); cyc();

        fetch_req = 1; fetch_addr = 0; cyc();
        fetch_addr = 1; cyc();
        load_en = 1; fetch_addr = 2; cyc();
        for (int i = 0; i < 3; i++) begin
            chk("abort L1 valid", fv1, 0);
            chk("abort L2 valid", fv2, 0);
            cyc();
        end
        fetch_req = 0; run_en = 0;
        for (int i = 0; i < 20; i++) begin
            if (i == 16) chk("overflow ready drop", rdy1, 0);
            load_valid = 1; load_data = 32'hA000_0000 + i; cyc();
        end
        chk("overflow count", lc1, 16);
        load_valid = 0; load_en = 0; cyc();

        load_en = 1; cyc();
        for (int i = 0; i < 3; i++) begin
            load_valid = 1; load_data = 32'hB000_0000 + i; cyc();
        end
        rst = 1; load_valid = 0; cyc();
        chk("rst mid-load done", done1, 0);
        chk("rst mid-load busy", busy1, 0);
        rst = 0; load_en = 0; run_en = 1; cyc();
        for (int i = 0; i < 16; i++) begin
            fetch_req = 1; fetch_addr = AW'(i); cyc();
            if (i == 0) chk("kept word 0", fd1, 32'hB000_0000);
            if (i == 5) chk("kept word 5", fd1, 32'hA000_0005);
        end
        fetch_req = 0; run_en = 0; cyc(); cyc();

        mode = 1;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 39) == 0) mode = $urandom_range(0, 2);
            rst         = ($urandom_range(0, 399) == 0);
            load_en     = (mode == 1);
            run_en      = (mode == 2) || ($urandom_range(0, 9) == 0);
            load_valid  = ($urandom_range(0, 2) != 0);
            load_data   = $urandom;
            fetch_req   = ($urandom_range(0, 3) != 0);
            fetch_addr  = AW'($urandom_range(0, 19));
            fetch_stall = ($urandom_range(0, 4) == 0);
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/instr_mem_ctrl.md
Name: instr_mem_ctrl

Overview:
- Parametrised instruction memory with an in-system program loader and a pipelined fetch port.
- Sits between the boot/host loader and the processor fetch stage.
- Generalises the fixed 2048x32 single-cycle instruction ROM: width, depth and read latency are configurable.
- Adds runtime loading, a stall-aware fetch handshake, and out-of-range fault reporting.

Parameters:
- DATA_W, 32: instruction word width.
- ADDR_W, 11: word-address width.
- DEPTH, 2048: implemented words; must satisfy DEPTH <= 2^ADDR_W.
- READ_LAT, 1: fetch latency in cycles; legal values are 1 or 2.
- NOP_WORD, 32'h0000_0000: word returned on a faulted fetch.

Ports:
- clka  in  1  clock; all logic is on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- load_en  in  1  request/hold load mode.
- load_valid  in  1  load word present.
- load_data  in  DATA_W  word to write.
- load_ready  out  1  loader can accept a word.
- load_count  out  ADDR_W+1  words written in the current load session.
- load_done  out  1  sticky flag: a load session has completed.
- run_en  in  1  start fetch mode from IDLE.
- fetch_req  in  1  fetch request.
- fetch_addr  in  ADDR_W  word address of the fetch.
- fetch_stall  in  1  freeze the fetch pipeline.
- fetch_valid  out  1  fetch_data is valid.
- fetch_data  out  DATA_W  fetched instruction.
- fetch_addr_out  out  ADDR_W  address belonging to fetch_data.
- fetch_fault  out  1  fetched address was >= DEPTH.
- busy  out  1  FSM is not in IDLE.

Behaviour:
- Reset:
  - State goes to IDLE.
  - All outputs go to 0: load_ready, load_count, load_done, fetch_valid, fetch_data, fetch_addr_out, fetch_fault, busy.
  - Write pointer clears and the pipeline is flushed.
  - Memory array contents are NOT reset.
  - Reset mid-load or mid-fetch aborts immediately; words already written remain.
- FSM states: IDLE, LOAD, RUN.
  - IDLE -> LOAD when load_en=1. load_en has priority over run_en.
  - IDLE -> RUN when run_en=1 and load_en=0.
  - LOAD -> IDLE when load_en=0. load_done is set that cycle.
  - RUN -> LOAD when load_en=1.
    - The pipeline is flushed: in-flight fetches are discarded and fetch_valid=0 from the next cycle.
    - The transition takes effect the next cycle.
  - RUN -> IDLE when run_en=0 and load_en=0. The pipeline is flushed the same way.
- LOAD:
  - On entry, write pointer and load_count clear to 0 and load_done clears.
  - load_ready=1 while in LOAD and pointer < DEPTH.
  - A write occurs when load_valid & load_ready: mem[ptr] <= load_data, then ptr and load_count increment.
  - At pointer == DEPTH, load_ready=0. Further words are dropped and the FSM stays in LOAD until load_en falls.
  - load_count saturates at DEPTH and holds its value after the session ends.
- RUN:
  - A fetch is accepted when fetch_req & !fetch_stall.
  - The result appears with fetch_valid=1 exactly READ_LAT cycles later, with fetch_addr_out equal to the accepted address.
  - Back-to-back accepts give one result per cycle.
  - fetch_valid=0 on cycles with no matching accept.
  - Stall (fetch_stall=1): no accept occurs, and all pipeline registers and outputs hold their values, including fetch_valid.
  - Out of range (fetch_addr >= DEPTH): no memory access; the result is fetch_data=NOP_WORD with fetch_fault=1.
  - fetch_fault=0 for in-range results.
- IDLE/LOAD: fetch_req is ignored and fetch_valid=0.
- busy=1 in LOAD and RUN.
- Memory: single-port synchronous RAM, inferable as block RAM. Load and fetch never overlap, so there are no read/write collisions.

Test Plan:
- Load then read: reset; load_en=1; stream 4 words 0x11111111..0x44444444; load_en=0 -> load_count=4, load_done=1. Then run_en=1; fetch addr 0..3 back-to-back -> with READ_LAT=1, fetch_valid on cycles +1..+4 with data in order and fetch_addr_out=0..3.
- Latency 2: same bench with READ_LAT=2 -> each result arrives 2 cycles after its accept, at full throughput.
- Stall: hold fetch_stall=1 for 3 cycles while a fetch of addr 2 is in flight -> fetch_data holds 0x33333333 and fetch_valid holds 1; nothing new is accepted; the pipeline resumes cleanly after stall drops.
- Fault: DEPTH=16; fetch addr 20 -> fetch_valid=1, fetch_fault=1, fetch_data=NOP_WORD. The next in-range fetch gives fetch_fault=0.
- Load overflow: DEPTH=16; offer 20 words -> load_ready drops after word 16; load_count=16; words 17..20 not written.
- Abort cases:
  - load_en asserted in RUN with 2 fetches in flight -> no fetch_valid pulses appear afterwards; FSM enters LOAD.
  - rst mid-LOAD -> FSM in IDLE, load_done=0, previously written words still readable after a later RUN.
